// File: rtl/down_cntr_timer.sv
// Loadable down-counting timer with one-shot / periodic modes, pause/resume and a
// registered one-cycle done pulse on expiry. Counts only on enable ticks while running.
module down_cntr_timer #(
   parameter int unsigned BITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [BITS-1:0] load_val,
   input  logic            start,
   input  logic            stop,
   input  logic            periodic,
   input  logic            enable,
   output logic [BITS-1:0] q,
   output logic            zero,
   output logic            done,
   output logic            busy
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StRun     = 2'd1;
   localparam logic [1:0] StHold    = 2'd2;
   localparam logic [1:0] StExpired = 2'd3;

   localparam logic [BITS-1:0] One = 1;

   logic [BITS-1:0] q_q, q_d;
   logic [BITS-1:0] rl_q, rl_d;
   logic [1:0]      state_q, state_d;
   logic            done_q, done_d;

   // stop dominates start everywhere; load dominates everything except reset
   always_comb begin
      q_d     = q_q;
      rl_d    = rl_q;
      state_d = state_q;
      done_d  = 1'b0;
      if (load) begin
         q_d     = load_val;
         rl_d    = load_val;
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start && !stop && (q_q != '0)) state_d = StRun;
            end
            StRun: begin
               if (stop) begin
                  state_d = StHold;
               end else if (enable) begin
                  if (q_q == One) begin
                     done_d = 1'b1;
                     if (periodic) begin
                        q_d = rl_q;
                     end else begin
                        q_d     = '0;
                        state_d = StExpired;
                     end
                  end else if (q_q != '0) begin
                     q_d = q_q - One;
                  end
               end
            end
            StHold: begin
               if (start && !stop) state_d = StRun;
            end
            StExpired: begin
               // restart from the reload value; no decrement on this edge
               if (start && !stop && (rl_q != '0)) begin
                  q_d     = rl_q;
                  state_d = StRun;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q     <= '0;
         rl_q    <= '0;
         state_q <= StIdle;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         rl_q    <= rl_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign zero = (q_q == '0);
   assign done = done_q;
   assign busy = (state_q == StRun);

endmodule
